// File: rtl/display_pkg.sv
// Shared definitions for the memory-mapped LED / seven-segment display peripheral:
// register map, store encodings and the active-low hex font.
package display_pkg;

  typedef enum logic [1:0] {
    REG_LED    = 2'd0,
    REG_HEX    = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  typedef enum logic [2:0] {
    STORE_SB = 3'b000,
    STORE_SH = 3'b001,
    STORE_SW = 3'b010
  } store_op_e;

  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_BLANK_LSB   = 4;
  localparam int unsigned STATUS_DIGIT_LSB = 0;
  localparam int unsigned STATUS_ERR_BIT   = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost slice.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/display_controller_seg_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = HEX_FONT[nibble];
  end

endmodule

// File: rtl/display_controller.sv
// Memory-mapped LED and 4-digit seven-segment display controller with a
// byte/half/word store path, combinational readback and a refresh scanner.
module display_controller
  import display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_address,
  input  logic        mem_write_enable,
  input  logic        mem_read_enable,
  input  logic [2:0]  store_operation,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic [15:0] leds,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      led_q;
  logic [15:0]      hex_q;
  logic             ctrl_en;
  logic [3:0]       ctrl_blank;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;
  logic [6:0]       seg_q;
  logic [3:0]       an_q;

  reg_sel_e    sel;
  logic [31:0] cur_word;
  logic [31:0] wr_mask;
  logic [31:0] wr_data;
  logic [31:0] merged;
  logic        op_valid;
  logic        misalign;
  logic        store_en;
  logic [3:0]  nibble;
  logic [6:0]  font_seg;
  logic        lit;
  logic [6:0]  seg_next;
  logic [3:0]  an_next;
  logic        unused_merged;

  assign hit = (mem_address[31:4] == BASE_ADDR[31:4]);
  assign sel = reg_sel_e'(mem_address[3:2]);

  always_comb begin
    cur_word = '0;
    case (sel)
      REG_LED:    cur_word = {16'h0000, led_q};
      REG_HEX:    cur_word = {16'h0000, hex_q};
      REG_CTRL:   cur_word = {24'h000000, ctrl_blank, 3'b000, ctrl_en};
      REG_STATUS: cur_word = {23'h0, err_q, 6'b000000, digit};
      default:    cur_word = '0;
    endcase
  end

  assign read_data = (hit && mem_read_enable) ? cur_word : '0;

  // Stores are merged into the current word by lane mask; only implemented bits are kept.
  always_comb begin
    wr_mask  = '0;
    wr_data  = '0;
    op_valid = 1'b0;
    misalign = 1'b0;
    case (store_operation)
      STORE_SB: begin
        op_valid = 1'b1;
        wr_mask  = 32'h0000_00FF << {mem_address[1:0], 3'b000};
        wr_data  = {4{write_data[7:0]}};
      end
      STORE_SH: begin
        op_valid = 1'b1;
        misalign = mem_address[0];
        wr_mask  = mem_address[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wr_data  = {2{write_data[15:0]}};
      end
      STORE_SW: begin
        op_valid = 1'b1;
        misalign = |mem_address[1:0];
        wr_mask  = '1;
        wr_data  = write_data;
      end
      default: ;
    endcase
    merged = (cur_word & ~wr_mask) | (wr_data & wr_mask);
  end

  assign store_en      = mem_write_enable && hit && op_valid;
  assign unused_merged = ^merged[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q      <= '0;
      hex_q      <= '0;
      ctrl_en    <= 1'b0;
      ctrl_blank <= '0;
      err_q      <= 1'b0;
    end else if (store_en) begin
      if (misalign) begin
        err_q <= 1'b1;
      end else begin
        case (sel)
          REG_LED:    led_q <= merged[15:0];
          REG_HEX:    hex_q <= merged[15:0];
          REG_CTRL: begin
            ctrl_en    <= merged[CTRL_ENABLE_BIT];
            ctrl_blank <= merged[CTRL_BLANK_LSB +: 4];
          end
          REG_STATUS: err_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign nibble = hex_q[{digit, 2'b00} +: 4];

  seg_decoder u_seg_decoder (
    .nibble   (nibble),
    .segments (font_seg)
  );

  always_comb begin
    lit      = ctrl_en && !ctrl_blank[digit];
    seg_next = lit ? font_seg : SEG_BLANK;
    an_next  = lit ? ~(4'b0001 << digit) : 4'hF;
  end

  // seg/an are registered together so a digit step never shows a mixed pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      digit <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        digit <= digit + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      seg_q <= seg_next;
      an_q  <= an_next;
    end
  end

  assign leds = led_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_display_controller.sv
// Self-checking bench for display_controller: directed scenarios with literal
// expectations plus randomized bus traffic checked against a behavioural model.
module tb_display_controller;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_address = 32'h0;
  logic        mem_write_enable = 1'b0;
  logic        mem_read_enable = 1'b0;
  logic [2:0]  store_operation = 3'b0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        hit;
  logic [15:0] leds;
  logic [6:0]  seg;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  display_controller #(.BASE_ADDR(BASE), .REFRESH_DIV(DIV)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .store_operation  (store_operation),
    .write_data       (write_data),
    .read_data        (read_data),
    .hit              (hit),
    .leds             (leds),
    .seg              (seg),
    .an               (an)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [31:0] impl [3] = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_00F1};
  logic [31:0] m_reg [3] = '{32'h0, 32'h0, 32'h0};
  logic        m_err = 1'b0;
  int          ticks = 0;
  logic [15:0] exp_leds = 16'h0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an = 4'hF;

  int          m_d;
  logic        m_lit;
  logic [3:0]  m_nib;

  function automatic logic [31:0] m_read(input logic [1:0] idx);
    if (idx == 2'd3) return (32'(m_err) << 8) | 32'((ticks / DIV) % 4);
    return m_reg[idx];
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
    logic [3:0] lanes;
    logic [7:0] b [4];
    bit bad, ok;
    int idx;
    idx = int'(a[3:2]);
    bad = 0; ok = 1; lanes = 4'h0;
    for (int k = 0; k < 4; k++) b[k] = 8'h00;
    case (op)
      3'd0: begin
        lanes = 4'b0001 << a[1:0];
        for (int k = 0; k < 4; k++) b[k] = d[7:0];
      end
      3'd1: begin
        bad = a[0];
        lanes = a[1] ? 4'b1100 : 4'b0011;
        for (int k = 0; k < 4; k++) b[k] = d[8*(k%2) +: 8];
      end
      3'd2: begin
        bad = (a[1:0] != 2'b00);
        lanes = 4'b1111;
        for (int k = 0; k < 4; k++) b[k] = d[8*k +: 8];
      end
      default: ok = 0;
    endcase
    if (ok) begin
      if (bad) m_err = 1'b1;
      else if (idx == 3) m_err = 1'b0;
      else begin
        for (int k = 0; k < 4; k++)
          if (lanes[k]) m_reg[idx][8*k +: 8] = b[k];
        m_reg[idx] = m_reg[idx] & impl[idx];
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int k = 0; k < 3; k++) m_reg[k] = 32'h0;
        m_err = 1'b0; ticks = 0;
        exp_leds = 16'h0; exp_seg = 7'h7F; exp_an = 4'hF;
      end else begin
        m_d   = (ticks / DIV) % 4;
        m_lit = m_reg[2][0] && !m_reg[2][4 + m_d];
        m_nib = m_reg[1][4*m_d +: 4];
        exp_an  = m_lit ? (4'hF ^ (4'b0001 << m_d)) : 4'hF;
        exp_seg = m_lit ? font[m_nib] : 7'h7F;
        if (mem_write_enable && mem_address[31:4] == BASE[31:4])
          model_store(mem_address, store_operation, write_data);
        exp_leds = m_reg[0][15:0];
        ticks++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  // Per-cycle compare against the model.
  logic        c_hit;
  logic [31:0] c_rd;
  initial begin
    forever begin
      @(negedge clk);
      chk("leds", 32'(leds), 32'(exp_leds));
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("an", 32'(an), 32'(exp_an));
      c_hit = (mem_address[31:4] == BASE[31:4]);
      chk("hit", 32'(hit), 32'(c_hit));
      c_rd = (mem_read_enable && c_hit) ? m_read(mem_address[3:2]) : 32'h0;
      chk("read_data", read_data, c_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
    @(posedge clk); #1;
    mem_address = a; store_operation = op; write_data = d;
    mem_write_enable = 1'b1; mem_read_enable = 1'b0;
    @(posedge clk); #1;
    mem_write_enable = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    mem_address = a; mem_read_enable = 1'b1; mem_write_enable = 1'b0;
    #1 v = read_data;
  endtask

  task automatic wait_run_start(input logic [3:0] prev_v, input logic [3:0] cur_v, input string name);
    logic [3:0] prev;
    bit found;
    found = 0;
    @(negedge clk);
    prev = an;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (prev == prev_v && an == cur_v) found = 1;
      else prev = an;
    end
    if (!found) timeout(name);
  endtask

  logic [3:0]  seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0]  hexseg [4] = '{7'h79, 7'h08, 7'h00, 7'h0E};
  logic [31:0] v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_an", 32'(an), 32'hF);
    reset_n = 1'b1;

    // Enable with HEX=0: an walks E,D,B,7,E, each for DIV cycles, showing '0'.
    do_store(BASE + 32'h8, 3'd2, 32'h1);
    wait_run_start(4'h7, 4'hE, "scan_start");
    for (int i = 0; i <= 16; i++) begin
      chk("scan_an", 32'(an), 32'(seq[(i / 4) % 4]));
      chk("scan_seg0", 32'(seg), 32'h40);
      @(negedge clk);
    end

    // LED word and byte stores, then readback.
    do_store(BASE, 3'd2, 32'h0000_A5F1);
    chk("sw_leds", 32'(leds), 32'hA5F1);
    do_store(BASE + 32'h1, 3'd0, 32'h0000_003C);
    chk("sb_leds", 32'(leds), 32'h3CF1);
    do_load(BASE, v);
    chk("load_led", v, 32'h0000_3CF1);

    // HEX digits decode.
    do_store(BASE + 32'h4, 3'd2, 32'h0000_F8A1);
    wait_run_start(4'h7, 4'hE, "hex_start");
    for (int i = 0; i < 4; i++) begin
      chk("hex_an", 32'(an), 32'(seq[i]));
      chk("hex_seg", 32'(seg), 32'(hexseg[i]));
      repeat (4) @(negedge clk);
    end

    // Digits 0 and 2 blanked.
    do_store(BASE + 32'h8, 3'd2, 32'h0000_0051);
    @(posedge clk);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("blank_slot", 32'(an == 4'hE || an == 4'hB), 32'h0);
      if (an == 4'hF) chk("blank_seg", 32'(seg), 32'h7F);
    end

    // Misaligned stores, error clear, out-of-window store.
    do_store(BASE + 32'h2, 3'd2, 32'hFFFF_FFFF);
    do_store(BASE + 32'h5, 3'd1, 32'h0000_FFFF);
    chk("misalign_leds", 32'(leds), 32'h3CF1);
    do_load(BASE + 32'h4, v);
    chk("misalign_hex", v, 32'h0000_F8A1);
    do_load(BASE + 32'hC, v);
    chk("status_err_set", 32'(v[8]), 32'h1);
    do_store(BASE + 32'hC, 3'd2, 32'h0);
    do_load(BASE + 32'hC, v);
    chk("status_err_clr", 32'(v[8]), 32'h0);
    @(posedge clk); #1;
    mem_address = BASE + 32'h10; mem_read_enable = 1'b0;
    #1 chk("outside_hit", 32'(hit), 32'h0);
    do_store(BASE + 32'h10, 3'd2, 32'h0000_1234);
    chk("outside_leds", 32'(leds), 32'h3CF1);

    // Reset mid-scan on digit 2.
    do_store(BASE + 32'h8, 3'd2, 32'h1);
    wait_run_start(4'hD, 4'hB, "digit2_wait");
    #2 reset_n = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_leds", 32'(leds), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 mem_address = BASE + 32'hC; mem_read_enable = 1'b1;
    #1 chk("rst_digit0", read_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_digit_hold", 32'(read_data[1:0]), 32'h0);
    end
    @(posedge clk); #1;
    chk("rst_digit_step", 32'(read_data[1:0]), 32'h1);

    // Randomized traffic.
    do_store(BASE + 32'h8, 3'd2, 32'h1);
    do_store(BASE + 32'h4, 3'd2, $urandom);
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 9))
        8:       mem_address = BASE + 32'h10 + 32'($urandom_range(0, 15));
        9:       mem_address = $urandom;
        default: mem_address = BASE + 32'($urandom_range(0, 15));
      endcase
      store_operation  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      write_data       = $urandom;
      mem_write_enable = 1'($urandom_range(0, 1));
      mem_read_enable  = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    mem_write_enable = 1'b0; mem_read_enable = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
